proc_core: RTL and testbench

//  Parametrised multi-cycle processor core: register file, A/G/IR registers, ALU, bus mux and step sequencer.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/proc_if.sv | 37 +++
 rtl/proc_alu.sv | 32 +++
 rtl/proc_core.sv | 112 +++++++++++
 tb/tb_proc_core.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared opcodes, step codes and ALU op codes for the multi-cycle core.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;

    function automatic alu_op_e alu_op_f(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_if.sv
// Core I/O bundle: run/din in, bus/status/debug out. zflag exists only with PROC_ZFLAG_EN.
interface proc_if #(
    parameter int DATA_W  = 9,
    parameter int REG_NUM = 8
);
    localparam int RIDX_W = $clog2(REG_NUM);

    logic              run;
    logic [DATA_W-1:0] din;
    logic [RIDX_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] bus;
    logic              busy;
    logic              done;
`ifdef PROC_ZFLAG_EN
    logic              zflag;
`endif

    modport master (
        output run, din, dbg_sel,
        input
`ifdef PROC_ZFLAG_EN
        zflag,
`endif
        dbg_q, bus, busy, done
    );

    modport slave (
        input run, din, dbg_sel,
        output
`ifdef PROC_ZFLAG_EN
        zflag,
`endif
        dbg_q, bus, busy, done
    );

endinterface

// File: rtl/proc_alu.sv
// Combinational A op B (add/sub/and/xor), wrapping; zero flag only with PROC_ZFLAG_EN.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o
`ifdef PROC_ZFLAG_EN
    ,
    output logic              zero_o
`endif
);

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD: res_o = a_i + b_i;
            ALU_SUB: res_o = a_i - b_i;
            ALU_AND: res_o = a_i & b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

`ifdef PROC_ZFLAG_EN
    assign zero_o = (res_o == '0);
`endif

endmodule

// File: rtl/proc_core.sv
// Multi-cycle core: register file, A/G/IR, step sequencer and bus mux; ALU in proc_alu.
// Optional PROC_ZFLAG_EN adds the zero flag and the mvnz opcode.
module proc_core
    import proc_pkg::*;
#(
    parameter int DATA_W  = 9,
    parameter int REG_NUM = 8
) (
    input  logic  clk,
    input  logic  resetn,
    proc_if.slave p
);
    localparam int RIDX_W = $clog2(REG_NUM);
    localparam int IR_W   = 3 + 2 * RIDX_W;

    step_e                          step_q;
    logic [IR_W-1:0]                ir_q;
    logic [DATA_W-1:0]              a_q, g_q;
    logic [REG_NUM-1:0][DATA_W-1:0] r_q;
`ifdef PROC_ZFLAG_EN
    logic                           zflag_q;
    logic                           alu_zero;
`endif

    logic [2:0]        op;
    logic [RIDX_W-1:0] rx, ry;
    logic [DATA_W-1:0] bus_d, alu_res;
    logic              done_d, r_we, a_we, g_we;

    assign op = ir_q[IR_W-1 -: 3];
    assign rx = ir_q[2*RIDX_W-1 -: RIDX_W];
    assign ry = ir_q[RIDX_W-1:0];

    // One bus source and at most one write enable per step.
    always_comb begin
        bus_d  = '0;
        done_d = 1'b0;
        r_we   = 1'b0;
        a_we   = 1'b0;
        g_we   = 1'b0;
        case (step_q)
            T1: begin
                case (op)
                    OP_MV:  begin bus_d = r_q[ry]; r_we = 1'b1; done_d = 1'b1; end
                    OP_MVI: begin bus_d = p.din;   r_we = 1'b1; done_d = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        bus_d = r_q[rx];
                        a_we  = 1'b1;
                    end
`ifdef PROC_ZFLAG_EN
                    OP_MVNZ: begin bus_d = r_q[ry]; r_we = ~zflag_q; done_d = 1'b1; end
`endif
                    default: done_d = 1'b1;
                endcase
            end
            T2: begin bus_d = r_q[ry]; g_we = 1'b1; end
            T3: begin bus_d = g_q; r_we = 1'b1; done_d = 1'b1; end
            default: ;
        endcase
    end

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i  (alu_op_f(op)),
        .a_i   (a_q),
        .b_i   (bus_d),
        .res_o (alu_res)
`ifdef PROC_ZFLAG_EN
        ,
        .zero_o(alu_zero)
`endif
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            r_q    <= '0;
`ifdef PROC_ZFLAG_EN
            zflag_q <= 1'b0;
`endif
        end else begin
            if (step_q == T0) begin
                if (p.run) begin
                    ir_q   <= p.din[IR_W-1:0];
                    step_q <= T1;
                end
            end else begin
                step_q <= done_d ? T0 : step_e'(step_q + 2'd1);
            end
            if (r_we) r_q[rx] <= bus_d;
            if (a_we) a_q <= bus_d;
            if (g_we) begin
                g_q <= alu_res;
`ifdef PROC_ZFLAG_EN
                zflag_q <= alu_zero;
`endif
            end
        end
    end

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign p.bus   = resetn ? bus_d : '0;
    assign p.done  = resetn & done_d;
    assign p.busy  = resetn & (step_q != T0);
    assign p.dbg_q = r_q[p.dbg_sel];
`ifdef PROC_ZFLAG_EN
    assign p.zflag = zflag_q;
`endif

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core (DATA_W=9, REG_NUM=8): instruction table plus reset/run-hold/zflag sequences.
module tb_proc_core;
    import proc_pkg::*;

    localparam int DW = 9;
    localparam int RN = 8;
`ifdef PROC_ZFLAG_EN
    localparam logic [DW-1:0] MVNZ_BUS = 9'h005;
`else
    localparam logic [DW-1:0] MVNZ_BUS = 9'h000;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    proc_if #(.DATA_W(DW), .REG_NUM(RN)) u_if ();
    proc_core #(.DATA_W(DW), .REG_NUM(RN)) u_dut (.clk(clk), .resetn(resetn), .p(u_if));

    typedef struct {
        string         name;
        logic [2:0]    op;
        int            rx;
        int            ry;
        logic [DW-1:0] imm;
        int            steps;
        logic [DW-1:0] exp_bus;
        int            chk_reg;
        logic [DW-1:0] exp_val;
    } vec_t;

    typedef struct {
        string         name;
        int            r;
        logic [DW-1:0] v;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left just after a falling edge with the core in T0.
    task automatic run_instr(input vec_t v, input bit hold);
        sb_t e;
        u_if.run = 1'b1;
        u_if.din = {v.op, 3'(v.rx), 3'(v.ry)};
        e.name = v.name; e.r = v.chk_reg; e.v = v.exp_val;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        u_if.din = v.imm;
        u_if.run = hold;
        for (int k = 1; k <= v.steps; k++) begin
            @(negedge clk);
            chk({v.name, " busy"}, 32'(u_if.busy), 32'd1);
            chk({v.name, " done"}, 32'(u_if.done), 32'(k == v.steps));
            if (k == v.steps) begin
                chk({v.name, " bus"}, 32'(u_if.bus), 32'(v.exp_bus));
                u_if.run = 1'b0;
            end
        end
        @(negedge clk);
        e = sb_q.pop_front();
        u_if.dbg_sel = 3'(e.r);
        #1;
        chk({e.name, " result"}, 32'(u_if.dbg_q), 32'(e.v));
        chk({e.name, " idle"}, 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{"mvi R2,5",    3'b001, 2, 0, 9'h005, 1, 9'h005, 2, 9'h005};
        tbl[1]  = '{"mv R3,R2",    3'b000, 3, 2, 9'h000, 1, 9'h005, 3, 9'h005};
        tbl[2]  = '{"mvi R0,1FF",  3'b001, 0, 0, 9'h1FF, 1, 9'h1FF, 0, 9'h1FF};
        tbl[3]  = '{"mvi R1,2",    3'b001, 1, 0, 9'h002, 1, 9'h002, 1, 9'h002};
        tbl[4]  = '{"add R0,R1",   3'b010, 0, 1, 9'h000, 3, 9'h001, 0, 9'h001};
        tbl[5]  = '{"sub R1,R0",   3'b011, 1, 0, 9'h000, 3, 9'h001, 1, 9'h001};
        tbl[6]  = '{"mvi R4,0F0",  3'b001, 4, 0, 9'h0F0, 1, 9'h0F0, 4, 9'h0F0};
        tbl[7]  = '{"mvi R5,03C",  3'b001, 5, 0, 9'h03C, 1, 9'h03C, 5, 9'h03C};
        tbl[8]  = '{"and R4,R5",   3'b100, 4, 5, 9'h000, 3, 9'h030, 4, 9'h030};
        tbl[9]  = '{"xor R5,R5",   3'b101, 5, 5, 9'h000, 3, 9'h000, 5, 9'h000};
        tbl[10] = '{"op111 R6,R7", 3'b111, 6, 7, 9'h000, 1, 9'h000, 6, 9'h000};
        tbl[11] = '{"add R1,R1",   3'b010, 1, 1, 9'h000, 3, 9'h002, 1, 9'h002};
        tbl[12] = '{"mv R1,R1",    3'b000, 1, 1, 9'h000, 1, 9'h002, 1, 9'h002};
        tbl[13] = '{"op110 R2,R3", 3'b110, 2, 3, 9'h000, 1, MVNZ_BUS, 2, 9'h005};

        // Reset held with run asserted: nothing starts, all registers clear.
        resetn = 1'b0;
        u_if.run = 1'b1;
        u_if.din = 9'b010_000_001;
        u_if.dbg_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(u_if.busy), 32'd0);
        chk("reset done", 32'(u_if.done), 32'd0);
        chk("reset bus", 32'(u_if.bus), 32'd0);
        for (int r = 0; r < RN; r++) begin
            u_if.dbg_sel = 3'(r);
            #1;
            chk($sformatf("reset R%0d", r), 32'(u_if.dbg_q), 32'd0);
        end
        resetn = 1'b1;
        u_if.run = 1'b0;
        @(negedge clk);
        chk("post-reset idle", 32'(u_if.busy), 32'd0);

        for (int i = 0; i < 14; i++) run_instr(tbl[i], 1'b0);

        // Reset in T2 of add R0,R1 aborts the instruction.
        u_if.run = 1'b1;
        u_if.din = 9'b010_000_001;
        @(posedge clk);
        #1;
        u_if.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in T2 busy", 32'(u_if.busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(u_if.busy), 32'd0);
        chk("abort done", 32'(u_if.done), 32'd0);
        chk("abort bus", 32'(u_if.bus), 32'd0);
        resetn = 1'b1;
        u_if.dbg_sel = 3'd0;
        #1;
        chk("abort R0", 32'(u_if.dbg_q), 32'd0);
        @(negedge clk);
        chk("abort stays T0", 32'(u_if.busy), 32'd0);

        // run held through the whole instruction and at done: no extra fetch.
        run_instr('{"mvi R3,7", 3'b001, 3, 0, 9'h007, 1, 9'h007, 3, 9'h007}, 1'b0);
        run_instr('{"add R2,R3 held", 3'b010, 2, 3, 9'h1AB, 3, 9'h007, 2, 9'h007}, 1'b1);

`ifdef PROC_ZFLAG_EN
        run_instr('{"mvi R2,1", 3'b001, 2, 0, 9'h001, 1, 9'h001, 2, 9'h001}, 1'b0);
        run_instr('{"sub R1,R1", 3'b011, 1, 1, 9'h000, 3, 9'h000, 1, 9'h000}, 1'b0);
        chk("zflag after zero", 32'(u_if.zflag), 32'd1);
        run_instr('{"mvnz blocked", 3'b110, 2, 3, 9'h000, 1, 9'h007, 2, 9'h001}, 1'b0);
        chk("zflag kept by mvnz", 32'(u_if.zflag), 32'd1);
        run_instr('{"add R1,R3", 3'b010, 1, 3, 9'h000, 3, 9'h007, 1, 9'h007}, 1'b0);
        chk("zflag after nonzero", 32'(u_if.zflag), 32'd0);
        run_instr('{"mvnz copies", 3'b110, 2, 3, 9'h000, 1, 9'h007, 2, 9'h007}, 1'b0);
`else
        run_instr('{"mvi R2,1", 3'b001, 2, 0, 9'h001, 1, 9'h001, 2, 9'h001}, 1'b0);
        run_instr('{"op110 illegal", 3'b110, 2, 3, 9'h000, 1, 9'h000, 2, 9'h001}, 1'b0);
`endif

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
